// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants and types for the memory-mapped I/O block.
// Holds the IO region tag, register offsets, STATUS bit positions and the
// offset decoder used by mmio_ctrl.
package mmio_pkg;

  // Upper two address bits that select the IO region.
  localparam logic [1:0] IoRegion = 2'b10;

  // Register offsets within the IO region (addr[7:0]).
  localparam logic [7:0] OffStatus = 8'h00;
  localparam logic [7:0] OffRx     = 8'h04;
  localparam logic [7:0] OffTx     = 8'h08;
  localparam logic [7:0] OffCyc    = 8'h10;
  localparam logic [7:0] OffIns    = 8'h14;
  localparam logic [7:0] OffCtrClr = 8'h18;

  // STATUS register bit positions.
  localparam int unsigned StTxEmpty  = 0;
  localparam int unsigned StRxValid  = 1;
  localparam int unsigned StRxFull   = 2;
  localparam int unsigned StTxDrop   = 3;
  localparam int unsigned StCountLsb = 8;

  typedef enum logic [2:0] {
    RegNone,
    RegStatus,
    RegRx,
    RegTx,
    RegCyc,
    RegIns,
    RegCtrClr
  } reg_e;

  function automatic reg_e decode_reg(input logic [7:0] off);
    case (off)
      OffStatus: return RegStatus;
      OffRx:     return RegRx;
      OffTx:     return RegTx;
      OffCyc:    return RegCyc;
      OffIns:    return RegIns;
      OffCtrClr: return RegCtrClr;
      default:   return RegNone;
    endcase
  endfunction

endpackage

// File: rtl/mmio_ctrl_fifo_sync.sv
// fifo_sync: single-clock FIFO with synchronous active-high reset.
// Ports:
//   clk_i, rst_i        clock and synchronous reset
//   push_i, wdata_i     write request and data (ignored when full)
//   pop_i, rdata_o      read request (ignored when empty) and head-of-queue data
//   full_o, empty_o     occupancy flags
//   count_o             number of stored entries (0..DEPTH)
// rdata_o shows the head entry combinationally; a push is never bypassed to it.
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata_i;
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      wptr_d = wptr_q + 1'b1;
    end
    if (do_pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // Storage needs no reset: stale entries are unreachable once pointers clear.
    mem_q <= mem_d;
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// mmio_ctrl: registered memory-mapped IO block (UART + performance counters).
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   addr, rd_en, wr_en, wdata  CPU access (EX stage); IO region is addr[31:30] == 2'b10
//   instr_commit               one pulse per retired instruction
//   uart_rx_data/valid/ready   byte stream from the UART receiver into the RX FIFO
//   uart_tx_data/valid/ready   holding register handshake to the UART transmitter
//   rdata                      read data, registered (1-cycle latency like DMEM/BIOS)
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RX_DEPTH  = 8,
  parameter int unsigned CTR_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             instr_commit,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  output logic             uart_rx_ready,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned RxAw = $clog2(RX_DEPTH);

  logic                 io_hit, rd_hit, wr_hit;
  reg_e                 reg_sel;
  logic [WIDTH-1:0]     status;

  logic [7:0]           rx_byte;
  logic                 rx_full, rx_empty, rx_push, rx_pop;
  logic [RxAw:0]        rx_count;

  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 tx_drop_q, tx_drop_d;
  logic [CTR_WIDTH-1:0] cycle_q, cycle_d;
  logic [CTR_WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;

  // Address and data bits outside the decoded fields are intentionally ignored.
  logic unused_bits;
  assign unused_bits = ^{addr[WIDTH-3:8], wdata[WIDTH-1:8]};

  assign io_hit  = (addr[WIDTH-1 -: 2] == IoRegion);
  assign rd_hit  = rd_en && io_hit;
  assign wr_hit  = wr_en && io_hit;
  assign reg_sel = decode_reg(addr[7:0]);

  assign uart_rx_ready = !rx_full;
  assign rx_push       = uart_rx_valid && !rx_full;
  assign rx_pop        = rd_hit && (reg_sel == RegRx) && !rx_empty;

  fifo_sync #(
    .WIDTH (8),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rx_push),
    .wdata_i (uart_rx_data),
    .pop_i   (rx_pop),
    .rdata_o (rx_byte),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  always_comb begin
    status                    = '0;
    status[StTxEmpty]         = !tx_valid_q;
    status[StRxValid]         = !rx_empty;
    status[StRxFull]          = rx_full;
    status[StTxDrop]          = tx_drop_q;
    status[StCountLsb +: 8]   = 8'(rx_count);
  end

  // Read mux, captured into rdata_q every cycle.
  always_comb begin
    rdata_d = '0;
    if (rd_hit) begin
      unique case (reg_sel)
        RegStatus: rdata_d = status;
        RegRx:     rdata_d = rx_empty ? '0 : WIDTH'(rx_byte);
        RegCyc:    rdata_d = WIDTH'(cycle_q);
        RegIns:    rdata_d = WIDTH'(instr_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_drop_d  = tx_drop_q;
    if (tx_valid_q && uart_tx_ready) begin
      tx_valid_d = 1'b0;
    end
    if (wr_hit && (reg_sel == RegTx)) begin
      // Decision uses the current valid, so a write in the handshake cycle is dropped.
      if (!tx_valid_q) begin
        tx_data_d  = wdata[7:0];
        tx_valid_d = 1'b1;
      end else begin
        tx_drop_d = 1'b1;
      end
    end
    if (wr_hit && (reg_sel == RegStatus) && wdata[StTxDrop]) begin
      tx_drop_d = 1'b0;
    end
  end

  always_comb begin
    cycle_d = cycle_q + CTR_WIDTH'(1);
    instr_d = instr_q + CTR_WIDTH'(instr_commit);
    if (wr_hit && (reg_sel == RegCtrClr)) begin
      cycle_d = '0;
      instr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_drop_q  <= 1'b0;
      cycle_q    <= '0;
      instr_q    <= '0;
      rdata_q    <= '0;
    end else begin
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_drop_q  <= tx_drop_d;
      cycle_q    <= cycle_d;
      instr_q    <= instr_d;
      rdata_q    <= rdata_d;
    end
  end

  assign uart_tx_data  = tx_data_q;
  assign uart_tx_valid = tx_valid_q;
  assign rdata         = rdata_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Testbench for mmio_ctrl: directed stimulus; read expectations go into a
// queue and a monitor compares them against rdata one cycle after each read.
module tb_mmio_ctrl;

  localparam logic [31:0] Io = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        rd_en, wr_en;
  logic [31:0] wdata;
  logic        instr_commit;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid, uart_rx_ready;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, uart_tx_ready;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mmio_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .wdata         (wdata),
    .instr_commit  (instr_commit),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .rdata         (rdata)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  // One cycle of stimulus, applied at a negedge and held until the next one.
  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] wd, input logic rv, input logic [7:0] rb,
                       input logic [31:0] want);
    addr          = a;
    rd_en         = r;
    wr_en         = w;
    wdata         = wd;
    uart_rx_valid = rv;
    uart_rx_data  = rb;
    if (r) exp_q.push_back(want);
    @(negedge clk);
    rd_en         = 1'b0;
    wr_en         = 1'b0;
    uart_rx_valid = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, input logic [31:0] want);
    drive(1'b1, 1'b0, Io | 32'(off), '0, 1'b0, 8'h00, want);
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    drive(1'b0, 1'b1, Io | 32'(off), d, 1'b0, 8'h00, '0);
  endtask

  task automatic push(input logic [7:0] b);
    drive(1'b0, 1'b0, '0, '0, 1'b1, b, '0);
  endtask

  // Monitor: a read issued in cycle N is compared at the negedge of cycle N+1.
  initial begin
    logic        was_rd;
    logic [31:0] want;
    forever begin
      @(posedge clk);
      was_rd = rd_en;
      @(negedge clk);
      if (was_rd) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
          want = exp_q.pop_front();
          chk("rdata", rdata, want);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; addr = '0; rd_en = 1'b0; wr_en = 1'b0; wdata = '0;
    instr_commit = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_rx_ready", 32'(uart_rx_ready), 32'd1);
    chk("reset_tx_valid", 32'(uart_tx_valid), 32'd0);
    rst = 1'b0;

    // 1: STATUS after reset
    rd(8'h00, 32'h0000_0001);
    chk("t1_rx_ready", 32'(uart_rx_ready), 32'd1);

    // 2: RX order, empty read, no-bypass, push+pop, non-IO and unmapped reads
    push(8'h41);
    push(8'h42);
    rd(8'h04, 32'h41);
    rd(8'h04, 32'h42);
    rd(8'h00, 32'h0000_0001);
    rd(8'h04, 32'h0);
    drive(1'b1, 1'b0, Io | 32'h04, '0, 1'b1, 8'h50, 32'h0);
    rd(8'h04, 32'h50);
    push(8'hA1);
    drive(1'b1, 1'b0, Io | 32'h04, '0, 1'b1, 8'hA2, 32'hA1);
    rd(8'h00, 32'h0000_0103);
    rd(8'h04, 32'hA2);
    push(8'h33);
    drive(1'b1, 1'b0, 32'h0000_0004, '0, 1'b0, 8'h00, 32'h0);
    rd(8'h0C, 32'h0);
    rd(8'h04, 32'h33);

    // 3: fill FIFO, push while full is ignored, pop reopens ready
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    chk("t3_rx_ready_full", 32'(uart_rx_ready), 32'd0);
    rd(8'h00, 32'h0000_0807);
    push(8'hEE);
    rd(8'h04, 32'h10);
    chk("t3_rx_ready_after_pop", 32'(uart_rx_ready), 32'd1);
    for (int i = 1; i < 8; i++) rd(8'h04, 32'(8'h10 + i));
    rd(8'h04, 32'h0);

    // 4: TX holding register, drop and clear
    wr(8'h08, 32'h55);
    wr(8'h08, 32'h66);
    chk("t4_tx_data", 32'(uart_tx_data), 32'h55);
    chk("t4_tx_valid", 32'(uart_tx_valid), 32'd1);
    rd(8'h00, 32'h0000_0008);
    uart_tx_ready = 1'b1;
    @(negedge clk);
    uart_tx_ready = 1'b0;
    chk("t4_tx_valid_drop", 32'(uart_tx_valid), 32'd0);
    rd(8'h00, 32'h0000_0009);
    wr(8'h00, 32'h8);
    rd(8'h00, 32'h0000_0001);
    wr(8'h08, 32'h77);
    uart_tx_ready = 1'b1;
    wr(8'h08, 32'h88);
    uart_tx_ready = 1'b0;
    chk("t4_handshake_write_valid", 32'(uart_tx_valid), 32'd0);
    chk("t4_handshake_write_data", 32'(uart_tx_data), 32'h77);
    rd(8'h00, 32'h0000_0009);
    wr(8'h00, 32'h8);

    // 5: counters, clear priority, wrap
    wr(8'h18, 32'h0);
    for (int i = 0; i < 100; i++) begin
      instr_commit = (i < 40);
      @(negedge clk);
    end
    instr_commit = 1'b0;
    rd(8'h10, 32'd100);
    rd(8'h14, 32'd40);
    instr_commit = 1'b1;
    wr(8'h18, 32'h0);
    instr_commit = 1'b0;
    rd(8'h10, 32'd0);
    rd(8'h14, 32'd0);
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    rd(8'h10, 32'hFFFF_FFFF);
    rd(8'h10, 32'h0);

    // 6: reset while TX pending and FIFO holds 3 bytes
    wr(8'h08, 32'hA5);
    push(8'h01);
    push(8'h02);
    push(8'h03);
    instr_commit = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    uart_rx_valid = 1'b1;
    uart_rx_data = 8'h04;
    @(negedge clk);
    rst = 1'b0;
    uart_rx_valid = 1'b0;
    instr_commit = 1'b0;
    chk("t6_tx_valid", 32'(uart_tx_valid), 32'd0);
    chk("t6_tx_data", 32'(uart_tx_data), 32'd0);
    chk("t6_rx_ready", 32'(uart_rx_ready), 32'd1);
    chk("t6_rdata", rdata, 32'd0);
    rd(8'h10, 32'd0);
    rd(8'h00, 32'h0000_0001);
    rd(8'h14, 32'd0);
    rd(8'h04, 32'd0);

    repeat (2) @(negedge clk);
    chk("scoreboard_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
